uart_cmd_bridge: RTL

- Byte-level command responder between the existing uart_rx and uart_tx blocks; gives a host PC register read/write access to on-chip logic over a single UART.
- Consumes received bytes on the uart_rx output interface and parses 2- or 3-byte commands.
- Drives a simple write strobe / read-address register port towards the fabric.
- Sends a 1-byte reply through the uart_tx input interface.

---
 rtl/uart_cmd_bridge.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/uart_cmd_bridge.sv
// Byte-level command responder between uart_rx and uart_tx: parses 'W' addr data / 'R' addr
// commands, drives a register write/read port and returns a single reply byte.
module uart_cmd_bridge #(
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned TIMEOUT = 16000,
    parameter logic [7:0]  CMD_WR  = 8'h57,
    parameter logic [7:0]  CMD_RD  = 8'h52,
    parameter logic [7:0]  ACK     = 8'h4B,
    parameter logic [7:0]  NAK     = 8'h3F
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [7:0]        rx_dat_i,
    input  logic              rx_new_data_i,
    output logic [7:0]        tx_dat_o,
    output logic              tx_new_data_o,
    input  logic              tx_rdy_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [7:0]        wr_data_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [7:0]        rd_data_i,
    output logic              timeout_o,
    output logic [7:0]        drop_cnt_o
);

    typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, DO_RD, RESP, TX_WAIT} state_t;

    localparam int unsigned     CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             is_wr;
    logic [7:0]       reply;

    logic             addr_ok;
    logic             busy;
    logic             reply_go;
    logic [7:0]       reply_val;
    logic             waiting;

    assign addr_ok = (rx_dat_i[7:ADDR_W] == '0);
    assign busy    = (state == DO_RD) || (state == RESP) || (state == TX_WAIT);

    // A reply is sent straight away when tx is ready, otherwise parked in RESP;
    // this gives the write reply at N+1 and the read reply at N+2.
    always_comb begin
        reply_go  = 1'b0;
        reply_val = NAK;
        case (state)
            IDLE:     reply_go = rx_new_data_i && (rx_dat_i != CMD_WR) && (rx_dat_i != CMD_RD);
            GET_ADDR: reply_go = rx_new_data_i && !addr_ok;
            GET_DATA: begin
                reply_go  = rx_new_data_i;
                reply_val = ACK;
            end
            DO_RD: begin
                reply_go  = 1'b1;
                reply_val = rd_data_i;
            end
            default: ;
        endcase
    end

    // Cycles with no byte and no state change advance the idle counter.
    always_comb begin
        waiting = 1'b0;
        if (!rx_new_data_i) begin
            case (state)
                GET_ADDR, GET_DATA: waiting = 1'b1;
                RESP:               waiting = !tx_rdy_i;
                TX_WAIT:            waiting = tx_rdy_i;
                default:            waiting = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state         <= IDLE;
            cnt           <= '0;
            is_wr         <= 1'b0;
            reply         <= '0;
            tx_dat_o      <= '0;
            tx_new_data_o <= 1'b0;
            wr_en_o       <= 1'b0;
            wr_addr_o     <= '0;
            wr_data_o     <= '0;
            rd_addr_o     <= '0;
            timeout_o     <= 1'b0;
            drop_cnt_o    <= '0;
        end else begin
            wr_en_o       <= 1'b0;
            tx_new_data_o <= 1'b0;
            timeout_o     <= 1'b0;

            if (rx_new_data_i && busy && (drop_cnt_o != 8'hFF))
                drop_cnt_o <= drop_cnt_o + 8'd1;

            if ((state == GET_DATA) && rx_new_data_i) begin
                wr_en_o   <= 1'b1;
                wr_data_o <= rx_dat_i;
            end

            if (reply_go) begin
                cnt <= '0;
                if (tx_rdy_i) begin
                    tx_dat_o      <= reply_val;
                    tx_new_data_o <= 1'b1;
                    state         <= TX_WAIT;
                end else begin
                    reply <= reply_val;
                    state <= RESP;
                end
            end else if (waiting) begin
                if (cnt == CNT_LAST) begin
                    cnt       <= '0;
                    timeout_o <= 1'b1;
                    state     <= IDLE;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
                case (state)
                    IDLE: begin
                        if (rx_new_data_i) begin
                            is_wr <= (rx_dat_i == CMD_WR);
                            state <= GET_ADDR;
                        end
                    end
                    GET_ADDR: begin
                        wr_addr_o <= rx_dat_i[ADDR_W-1:0];
                        rd_addr_o <= rx_dat_i[ADDR_W-1:0];
                        state     <= is_wr ? GET_DATA : DO_RD;
                    end
                    RESP: begin
                        if (tx_rdy_i) begin
                            tx_dat_o      <= reply;
                            tx_new_data_o <= 1'b1;
                            state         <= TX_WAIT;
                        end
                    end
                    TX_WAIT: begin
                        if (!tx_rdy_i)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
